// File: rtl/axis_chk_syn.sv
// AXI-Stream sink/checker for the synthetic counter stream.
// Drives tready with optional periodic stalls and tracks data/keep/framing errors.
module axis_chk_syn #(
    parameter int TDATA_NUM_BYTES = 128,
    parameter logic [8*TDATA_NUM_BYTES-9:0] FIXED = '0,
    parameter int ERR_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         clr,
    input  logic [7:0]                   stall_period,
    input  logic [7:0]                   frame_len,
    input  logic [8*TDATA_NUM_BYTES-1:0] S_AXIS_tdata,
    input  logic [TDATA_NUM_BYTES-1:0]   S_AXIS_tkeep,
    input  logic                         S_AXIS_tlast,
    input  logic                         S_AXIS_tvalid,
    output logic                         S_AXIS_tready,
    output logic                         locked,
    output logic [31:0]                  beat_cnt,
    output logic [31:0]                  frame_cnt,
    output logic [ERR_W-1:0]             err_data_cnt,
    output logic [ERR_W-1:0]             err_last_cnt,
    output logic [ERR_W-1:0]             err_keep_cnt,
    output logic                         err_any
);

    localparam int W = 8 * TDATA_NUM_BYTES;

    typedef enum logic [1:0] {IDLE, SYNC, CHECK} state_t;

    state_t     state;
    logic [7:0] stall_ctr;
    logic [7:0] exp_v;
    logic [7:0] idx;
    logic       stall_hit;
    logic       live;
    logic       d_err;
    logic       k_err;
    logic       at_end;
    logic       l_ok;
    logic       l_err;

    function automatic logic [ERR_W-1:0] sat_inc(
        input logic [ERR_W-1:0] v,
        input logic             hit
    );
        return (hit && (v != '1)) ? v + ERR_W'(1) : v;
    endfunction

    assign stall_hit = (stall_period != 8'd0) && (stall_ctr == stall_period);
    assign live      = S_AXIS_tvalid && S_AXIS_tready && (state != IDLE);
    assign d_err     = (S_AXIS_tdata[W-1:8] != FIXED) ||
                       ((state == CHECK) && (S_AXIS_tdata[7:0] != exp_v));
    assign k_err     = !(&S_AXIS_tkeep);
    // 8-bit wrap makes frame_len=0 mean a 256-beat frame
    assign at_end    = (idx == frame_len - 8'd1);
    assign l_ok      = S_AXIS_tlast && at_end;
    assign l_err     = S_AXIS_tlast != at_end;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state         <= (!rst && en) ? SYNC : IDLE;
            S_AXIS_tready <= 1'b0;
            stall_ctr     <= 8'd0;
            exp_v         <= 8'd0;
            idx           <= 8'd0;
            locked        <= 1'b0;
            beat_cnt      <= 32'd0;
            frame_cnt     <= 32'd0;
            err_data_cnt  <= '0;
            err_last_cnt  <= '0;
            err_keep_cnt  <= '0;
            err_any       <= 1'b0;
        end else begin
            S_AXIS_tready <= en && !stall_hit;
            if (en)
                stall_ctr <= stall_hit ? 8'd0 : stall_ctr + 8'd1;

            unique case (state)
                IDLE:    if (en) state <= SYNC;
                SYNC:    if (live) begin
                             state  <= CHECK;
                             locked <= 1'b1;
                         end
                default: ;
            endcase

            if (live) begin
                beat_cnt     <= beat_cnt + 32'd1;
                exp_v        <= S_AXIS_tdata[7:0] + 8'd1;
                err_data_cnt <= sat_inc(err_data_cnt, d_err);
                err_keep_cnt <= sat_inc(err_keep_cnt, k_err);
                err_last_cnt <= sat_inc(err_last_cnt, l_err);
                if (l_ok)
                    frame_cnt <= frame_cnt + 32'd1;
                idx <= (S_AXIS_tlast || at_end) ? 8'd0 : idx + 8'd1;
                if (d_err || k_err || l_err)
                    err_any <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_chk_syn.sv
// Directed + randomized bench for axis_chk_syn against a beat-level model.
module tb_axis_chk_syn;

    localparam int NB = 128;
    localparam int W  = 8 * NB;

    logic          clk = 1'b0;
    logic          rst, en, clr;
    logic [7:0]    sp, fl;
    logic [W-1:0]  tdata;
    logic [NB-1:0] tkeep;
    logic          tlast, tvalid, tready, locked, err_any;
    logic [31:0]   beat_cnt, frame_cnt;
    logic [15:0]   edc, elc, ekc;

    int checks = 0;
    int failures = 0;

    int m_beats, m_frames, m_errd, m_errl, m_errk, m_pos, m_exp;
    bit m_locked, m_any;

    always #5 clk = ~clk;

    axis_chk_syn dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .stall_period(sp), .frame_len(fl),
        .S_AXIS_tdata(tdata), .S_AXIS_tkeep(tkeep),
        .S_AXIS_tlast(tlast), .S_AXIS_tvalid(tvalid),
        .S_AXIS_tready(tready), .locked(locked),
        .beat_cnt(beat_cnt), .frame_cnt(frame_cnt),
        .err_data_cnt(edc), .err_last_cnt(elc),
        .err_keep_cnt(ekc), .err_any(err_any)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_beats = 0; m_frames = 0; m_errd = 0; m_errl = 0; m_errk = 0;
        m_pos = 0; m_exp = 0; m_locked = 0; m_any = 0;
    endtask

    function automatic int flen();
        return (fl == 8'd0) ? 256 : int'(fl);
    endfunction

    function automatic bit want_last();
        return m_pos == flen() - 1;
    endfunction

    task automatic model_beat(int d, bit kbad, bit ubad, bit l);
        bit at_end = want_last();
        bit derr = ubad || (m_locked && d != m_exp);
        m_beats++;
        if (derr) m_errd++;
        if (kbad) m_errk++;
        if (l && at_end) begin
            m_frames++; m_pos = 0;
        end else if (l || at_end) begin
            m_errl++; m_pos = 0; m_any = 1;
        end else begin
            m_pos++;
        end
        if (derr || kbad) m_any = 1;
        m_exp = (d + 1) % 256;
        m_locked = 1;
    endtask

    task automatic check_all(string p);
        chk({p, ".beat_cnt"}, beat_cnt, m_beats);
        chk({p, ".frame_cnt"}, frame_cnt, m_frames);
        chk({p, ".err_data"}, 32'(edc), m_errd);
        chk({p, ".err_last"}, 32'(elc), m_errl);
        chk({p, ".err_keep"}, 32'(ekc), m_errk);
        chk({p, ".err_any"}, 32'(err_any), 32'(m_any));
        chk({p, ".locked"}, 32'(locked), 32'(m_locked));
    endtask

    // lmode: 0 = tlast from model position, 1 = force high, 2 = force low
    task automatic send(int d, bit kbad, bit ubad, int lmode);
        bit l;
        int n = 0;
        l = (lmode == 0) ? want_last() : (lmode == 1);
        tdata = '0;
        tdata[7:0] = 8'(d);
        if (ubad) tdata[W-5] = 1'b1;
        tkeep = '1;
        if (kbad) tkeep[3] = 1'b0;
        tlast = l;
        tvalid = 1'b1;
        while (!tready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!tready) begin
            chk("accept_timeout", 32'(tready), 32'd1);
            tvalid = 1'b0;
            return;
        end
        @(negedge clk);
        tvalid = 1'b0;
        model_beat(d, kbad, ubad, l);
    endtask

    task automatic send_n(int start, int n);
        for (int i = 0; i < n; i++)
            send((start + i) % 256, 0, 0, 0);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_reset();
    endtask

    initial begin
        int d, lows, n;
        bit rdy, l;
        rst = 1'b1; en = 1'b0; clr = 1'b0; sp = 8'd0; fl = 8'd32;
        tdata = '0; tkeep = '1; tlast = 1'b0; tvalid = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.tready", 32'(tready), 32'd0);
        check_all("rst");

        en = 1'b1;
        @(negedge clk);
        chk("en.tready", 32'(tready), 32'd1);
        send_n(0, 128);
        check_all("count");
        chk("count.frames4", frame_cnt, 32'd4);

        pulse_clr();
        check_all("clr_a");
        send_n(200, 64);
        check_all("wrap");
        chk("wrap.beats64", beat_cnt, 32'd64);

        send_n(m_exp, 8);
        send(8'h55, 0, 0, 0);
        send(8'h56, 0, 0, 0);
        send(8'h57, 0, 0, 0);
        send(8'h58, 1, 0, 0);
        send_n(8'h59, 7);
        check_all("corrupt");
        chk("corrupt.edata1", 32'(edc), 32'd1);
        chk("corrupt.ekeep1", 32'(ekc), 32'd1);

        fl = 8'd8;
        pulse_clr();
        d = $urandom_range(0, 255);
        for (int i = 0; i < 5; i++)
            send((d + i) % 256, 0, 0, (i == 4) ? 1 : 0);
        for (int i = 5; i < 13; i++)
            send((d + i) % 256, 0, 0, (i == 12) ? 2 : 0);
        chk("frame.elast2", 32'(elc), 32'd2);
        chk("frame.frames0", frame_cnt, 32'd0);
        send_n((d + 13) % 256, 8);
        check_all("frame");
        chk("frame.frames1", frame_cnt, 32'd1);

        sp = 8'd3;
        fl = 8'($urandom_range(4, 20));
        pulse_clr();
        @(negedge clk);
        d = $urandom_range(0, 255);
        lows = 0;
        for (int c = 0; c < 400; c++) begin
            tdata = '0;
            tdata[7:0] = 8'(d);
            tkeep = '1;
            l = want_last();
            tlast = l;
            tvalid = 1'b1;
            rdy = tready;
            if (!rdy) lows++;
            @(negedge clk);
            if (rdy) begin
                model_beat(d, 0, 0, l);
                d = (d + 1) % 256;
            end
        end
        tvalid = 1'b0;
        chk("stall.lows", 32'(lows), 32'd100);
        check_all("stall");
        if (m_pos == 0) begin
            send(d, 0, 0, 0);
            d = (d + 1) % 256;
        end
        en = 1'b0;
        repeat (50) @(negedge clk);
        chk("pause.tready", 32'(tready), 32'd0);
        en = 1'b1;
        n = 0;
        while (m_pos != 0 && n < 64) begin
            send(d, 0, 0, 0);
            d = (d + 1) % 256;
            n++;
        end
        check_all("resume");

        sp = 8'd0;
        n = 0;
        while (!tready && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk("clrbeat.ready", 32'(tready), 32'd1);
        tdata = '0;
        tdata[7:0] = 8'(d);
        tkeep = '1;
        tlast = 1'b0;
        tvalid = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        tvalid = 1'b0;
        model_reset();
        chk("clrbeat.tready", 32'(tready), 32'd0);
        check_all("clrbeat");
        d = $urandom_range(0, 255);
        send(d, 0, 0, 0);
        send((d + 1) % 256, 0, 0, 0);
        send((d + 2) % 256, 0, 1, 0);
        send_n((d + 3) % 256, 3);
        check_all("relock");

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("rst2.tready", 32'(tready), 32'd0);
        check_all("rst2");
        send_n($urandom_range(0, 255), 3);
        check_all("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_chk_syn.md
Name: axis_chk_syn

Overview:
- AXI-Stream sink and checker: the receiving end for the synthetic stream produced by axis_stim_syn.
- Drives tready, with optional periodic backpressure.
- Checks each accepted beat for payload pattern, tkeep and tlast framing, and keeps saturating error and traffic counters.
- Sits at the end of a datapath under test (or loopback) in lab and sim builds.
- Status is read by software or the bench.

Parameters:
- TDATA_NUM_BYTES, 128, tdata width in bytes (W = 8*TDATA_NUM_BYTES).
- FIXED, all-zero (W-8 bits), required constant upper field of every beat, tdata[W-1:8].
- ERR_W, 16, width of each error counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  enables acceptance; tready is low while en=0.
- clr  in  1  one-cycle synchronous clear of counters and sync state.
- stall_period  in  8  0 = no backpressure; N>0 = tready low for 1 cycle every N+1 cycles.
- frame_len  in  8  beats per frame; 0 means 256.
- S_AXIS_tdata  in  W  payload.
- S_AXIS_tkeep  in  W/8  byte enables; must be all ones.
- S_AXIS_tlast  in  1  end of frame.
- S_AXIS_tvalid  in  1  valid.
- S_AXIS_tready  out  1  ready (registered).
- locked  out  1  pattern sync acquired.
- beat_cnt  out  32  accepted beats (wraps).
- frame_cnt  out  32  good tlast-terminated frames (wraps).
- err_data_cnt  out  ERR_W  payload mismatches (saturating).
- err_last_cnt  out  ERR_W  framing errors (saturating).
- err_keep_cnt  out  ERR_W  tkeep errors (saturating).
- err_any  out  1  sticky; set on any error, cleared only by rst or clr.

Behaviour:
- Reset: every output is 0, including S_AXIS_tready. State is IDLE; expected value, frame index and stall counter are 0.
- Beat is accepted when S_AXIS_tvalid and S_AXIS_tready are both high.
- S_AXIS_tready is registered:
  - next value = en and not stall_hit and not clr.
  - stall_hit = (stall_period != 0) and (stall_ctr == stall_period).
  - stall_ctr is 8-bit; it counts cycles while en=1, returns to 0 after stall_hit, and holds while en=0.
- FSM:
  - IDLE: tready low. Goes to SYNC when en=1.
  - SYNC: the first accepted beat loads exp = tdata[7:0]+1. It does not compare the counter, but still checks FIXED, tkeep and tlast. Then locked=1 and go to CHECK.
  - CHECK: each accepted beat is compared to exp.
  - en=0 in SYNC or CHECK: tready drops the next cycle; state, exp and frame index are held. Resume on en=1 with no error.
- Data check on each accepted beat in CHECK:
  - Mismatch if tdata[7:0] != exp or tdata[W-1:8] != FIXED. A mismatch increments err_data_cnt.
  - exp resyncs to tdata[7:0]+1 on every beat, so one corrupted beat counts 1 error, not a storm.
  - exp is 8-bit and wraps 255->0 with no error.
- tkeep check: any zero bit on an accepted beat increments err_keep_cnt (SYNC or CHECK).
- Framing, with idx as the 8-bit beat-in-frame counter:
  - Last beat is expected at idx == frame_len-1 (8-bit math, so frame_len=0 gives 256 beats).
  - tlast where expected: frame_cnt+1, idx=0.
  - Early tlast: err_last_cnt+1, idx=0, frame_cnt unchanged.
  - Missing tlast where expected: err_last_cnt+1, idx=0 (boundary resync).
  - Otherwise idx+1.
- frame_len changes take effect at the next idx comparison; this is the user's responsibility mid-frame.
- Same beat with multiple error types: each applicable counter increments once.
- Counter update latency: all counters and err_any update on the cycle after the accepting edge, i.e. they are registered on the same edge as acceptance.
- Error counters saturate at all ones. beat_cnt and frame_cnt wrap.
- clr:
  - Same effect as rst on counters, err_any, locked, idx and stall_ctr.
  - FSM goes to SYNC if en=1, else IDLE.
  - A beat accepted in the clr cycle is discarded: not counted, not checked.
  - clr has priority over every simultaneous event.
- rst mid-frame: abandons the frame; the next beat is treated as the first of a frame in SYNC.

Test Plan:
- Reset, then en=1, stall_period=0, frame_len=32, and 4 frames of 32 beats with tdata[7:0] counting 0..127 and FIXED upper field -> tready high 1 cycle after en; beat_cnt=128, frame_cnt=4, all err=0, locked=1.
- Stream starts at tdata[7:0]=200 and runs 64 beats through the wrap -> locked on beat 1; no errors across 255->0; beat_cnt=64.
- Corrupt one beat (tdata[7:0]=0x55 instead of 0x10) plus one beat with tkeep bit 3 cleared -> err_data_cnt=1, err_keep_cnt=1, err_any=1, following beats clean.
- frame_len=8: tlast on beat 5, then a frame with no tlast on beat 8 -> err_last_cnt=2, frame_cnt excludes both, next correct frame increments frame_cnt.
- stall_period=3 with tvalid held high for 400 cycles -> tready low exactly 1 cycle in 4 (100 low); en=0 for 50 cycles mid-frame then en=1 -> no errors, frame completes normally.
- clr pulse coincident with an accepted beat, with counters non-zero -> all counters 0, err_any=0, locked=0; the beat is not counted; next beat relocks.
